// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorting network: an input register bank followed by LAT compare-exchange stages.
// Optional feature macro BITONIC_TAG_EN adds position tags (idx_out) and a stable {value, idx} compare key.
module bitonic_sort_pipe #(
    parameter int DATA_W = 8,
    parameter int N      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_desc,
    input  logic [N*DATA_W-1:0]    data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*DATA_W-1:0]    data_out,
`ifdef BITONIC_TAG_EN
    output logic [N*$clog2(N)-1:0] idx_out,
`endif
    output logic                   busy
);

    localparam int LOG2N = $clog2(N);
    localparam int LAT   = LOG2N * (LOG2N + 1) / 2;
`ifdef BITONIC_TAG_EN
    localparam int KEY_W = DATA_W + LOG2N;
`else
    localparam int KEY_W = DATA_W;
`endif

    function automatic logic cx_swap(input logic [KEY_W-1:0] key_a,
                                     input logic [KEY_W-1:0] key_b,
                                     input logic             up);
        logic swap;
        if (up) begin
            swap = (key_a > key_b);
        end else begin
            swap = (key_a < key_b);
        end
        return swap;
    endfunction

    logic                adv_s;
    logic [LAT:0]        valid_q, valid_d;
    logic [LAT-1:0]      desc_q, desc_d;
    logic [N*DATA_W-1:0] data_q    [0:LAT];
    logic [N*DATA_W-1:0] data_d    [0:LAT];
    logic [N*DATA_W-1:0] cx_data_s [1:LAT];
`ifdef BITONIC_TAG_EN
    logic [N*LOG2N-1:0]  idx_q      [0:LAT];
    logic [N*LOG2N-1:0]  idx_d      [0:LAT];
    logic [N*LOG2N-1:0]  cx_idx_s   [1:LAT];
    logic [N*LOG2N-1:0]  idx_init_s;

    // Tags 0..N-1 label each element with its original input position.
    always_comb begin
        idx_init_s = '0;
        for (int k = 0; k < N; k++) begin
            idx_init_s[k*LOG2N +: LOG2N] = LOG2N'(k);
        end
    end
`endif

    genvar gp, gk;
    generate
        for (gp = 1; gp <= LOG2N; gp++) begin : g_phase
            for (gk = 0; gk < gp; gk++) begin : g_step
                localparam int S    = gp * (gp - 1) / 2 + gk + 1;
                localparam int DIST = 1 << (gp - 1 - gk);
                logic [N*DATA_W-1:0] stage_data_s;
                logic [KEY_W-1:0]    key_a_s;
                logic [KEY_W-1:0]    key_b_s;
                logic                up_s;
`ifdef BITONIC_TAG_EN
                logic [N*LOG2N-1:0]  stage_idx_s;
`endif
                // Compare-exchange each (i, i+DIST) pair; block direction comes from bit gp of i, flipped by desc.
                always_comb begin
                    stage_data_s = data_q[S-1];
                    key_a_s      = '0;
                    key_b_s      = '0;
                    up_s         = 1'b0;
`ifdef BITONIC_TAG_EN
                    stage_idx_s  = idx_q[S-1];
`endif
                    for (int i = 0; i < N; i++) begin
                        if ((i & DIST) == 0) begin
`ifdef BITONIC_TAG_EN
                            key_a_s = {data_q[S-1][i*DATA_W +: DATA_W], idx_q[S-1][i*LOG2N +: LOG2N]};
                            key_b_s = {data_q[S-1][(i+DIST)*DATA_W +: DATA_W],
                                       idx_q[S-1][(i+DIST)*LOG2N +: LOG2N]};
`else
                            key_a_s = data_q[S-1][i*DATA_W +: DATA_W];
                            key_b_s = data_q[S-1][(i+DIST)*DATA_W +: DATA_W];
`endif
                            up_s = (((i >> gp) & 1) == 0) ^ desc_q[S-1];
                            if (cx_swap(key_a_s, key_b_s, up_s)) begin
                                stage_data_s[i*DATA_W +: DATA_W]        = data_q[S-1][(i+DIST)*DATA_W +: DATA_W];
                                stage_data_s[(i+DIST)*DATA_W +: DATA_W] = data_q[S-1][i*DATA_W +: DATA_W];
`ifdef BITONIC_TAG_EN
                                stage_idx_s[i*LOG2N +: LOG2N]        = idx_q[S-1][(i+DIST)*LOG2N +: LOG2N];
                                stage_idx_s[(i+DIST)*LOG2N +: LOG2N] = idx_q[S-1][i*LOG2N +: LOG2N];
`endif
                            end else begin
                            end
                        end else begin
                        end
                    end
                end

                assign cx_data_s[S] = stage_data_s;
`ifdef BITONIC_TAG_EN
                assign cx_idx_s[S]  = stage_idx_s;
`endif
            end
        end
    endgenerate

    // The whole pipe moves as one unless the output holds an unaccepted vector.
    always_comb begin
        adv_s = !valid_q[LAT] || out_ready;
    end

    // Next-state of every bank: shift on advance, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        desc_d  = desc_q;
        data_d  = data_q;
`ifdef BITONIC_TAG_EN
        idx_d   = idx_q;
`endif
        if (adv_s) begin
            valid_d   = {valid_q[LAT-1:0], in_valid};
            desc_d[0] = in_desc;
            data_d[0] = data_in;
`ifdef BITONIC_TAG_EN
            idx_d[0]  = idx_init_s;
`endif
            for (int s = 1; s < LAT; s++) begin
                desc_d[s] = desc_q[s-1];
            end
            for (int s = 1; s <= LAT; s++) begin
                data_d[s] = cx_data_s[s];
`ifdef BITONIC_TAG_EN
                idx_d[s]  = cx_idx_s[s];
`endif
            end
        end else begin
        end
    end

    // Pipeline register banks; reset empties the pipe and clears data/mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            desc_q  <= '0;
            for (int s = 0; s <= LAT; s++) begin
                data_q[s] <= '0;
`ifdef BITONIC_TAG_EN
                idx_q[s]  <= '0;
`endif
            end
        end else begin
            valid_q <= valid_d;
            desc_q  <= desc_d;
            data_q  <= data_d;
`ifdef BITONIC_TAG_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = valid_q[LAT];
    assign data_out  = data_q[LAT];
    assign busy      = |valid_q;
`ifdef BITONIC_TAG_EN
    assign idx_out   = idx_q[LAT];
`endif

    bitonic_sort_pipe_chk #(.W(N*DATA_W)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .data_out  (data_out)
    );

endmodule

// Handshake properties of the sorter output.
module bitonic_sort_pipe_chk #(
    parameter int W = 64
) (
    input logic         clk,
    input logic         rst_n,
    input logic         out_valid,
    input logic         out_ready,
    input logic         in_ready,
    input logic [W-1:0] data_out
);

    a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(data_out)));

    a_ready_rule: assert property (@(posedge clk) disable iff (!rst_n)
        in_ready == (!out_valid || out_ready));

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Directed bench for bitonic_sort_pipe (N=8, DATA_W=8) with a cycle-level model of the output stream.
module tb_bitonic_sort_pipe;

    localparam int DATA_W = 8;
    localparam int N      = 8;
    localparam int LAT    = 6;
    localparam int VW     = N * DATA_W;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_desc   = 1'b0;
    logic          out_ready = 1'b1;
    logic [VW-1:0] data_in   = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [VW-1:0] data_out;
`ifdef BITONIC_TAG_EN
    logic [23:0]   idx_out;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   nsent  = 0;
    int   ndeq   = 0;
    logic ordy_mode = 1'b0;

    // Model: expected contents of each bank (valid, sorted data, expected tags, tag-check flag).
    logic [LAT:0]  mv;
    logic [LAT:0]  mc;
    logic [VW-1:0] md [0:LAT];
    logic [23:0]   mi [0:LAT];

    bitonic_sort_pipe #(.DATA_W(DATA_W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_desc   (in_desc),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
`ifdef BITONIC_TAG_EN
        .idx_out   (idx_out),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                       input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5,
                                       input logic [7:0] e6, input logic [7:0] e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [23:0] pt(input logic [2:0] i0, input logic [2:0] i1, input logic [2:0] i2,
                                       input logic [2:0] i3, input logic [2:0] i4, input logic [2:0] i5,
                                       input logic [2:0] i6, input logic [2:0] i7);
        return {i7, i6, i5, i4, i3, i2, i1, i0};
    endfunction

    task automatic model_clear();
        mv = '0;
        mc = '0;
        for (int s = 0; s <= LAT; s++) begin
            md[s] = '0;
            mi[s] = '0;
        end
    endtask

    // One clock cycle: drive inputs at negedge, check outputs 1 time unit later, advance the model.
    task automatic tick(input logic iv, input logic [63:0] din, input logic dsc, input logic [63:0] dexp,
                        input logic [23:0] iexp, input logic ichk, output logic took);
        logic adv;
        @(negedge clk);
        out_ready = ordy_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        in_valid  = iv;
        data_in   = din;
        in_desc   = dsc;
        #1;
        check_eq("out_valid", 64'(out_valid), 64'(mv[LAT]));
        check_eq("in_ready", 64'(in_ready), 64'(!mv[LAT] || out_ready));
        check_eq("busy", 64'(busy), 64'(|mv));
        if (mv[LAT]) begin
            check_eq("data_out", data_out, md[LAT]);
        end
`ifdef BITONIC_TAG_EN
        if (mv[LAT] && mc[LAT]) begin
            check_eq("idx_out", 64'(idx_out), 64'(mi[LAT]));
        end
`endif
        if (out_valid && out_ready) begin
            ndeq++;
        end
        adv  = !mv[LAT] || out_ready;
        took = iv && adv;
        if (adv) begin
            for (int s = LAT; s > 0; s--) begin
                mv[s] = mv[s-1];
                mc[s] = mc[s-1];
                md[s] = md[s-1];
                mi[s] = mi[s-1];
            end
            mv[0] = iv;
            mc[0] = ichk;
            md[0] = dexp;
            mi[0] = iexp;
        end
        cyc++;
    endtask

    task automatic send(input logic [63:0] din, input logic dsc, input logic [63:0] dexp,
                        input logic [23:0] iexp, input logic ichk);
        logic took;
        int   n;
        took = 1'b0;
        n    = 0;
        while (!took && n < 50) begin
            tick(1'b1, din, dsc, dexp, iexp, ichk, took);
            n++;
        end
        if (!took) begin
            check_eq("send_timeout", 64'(took), 64'd1);
        end
        nsent++;
    endtask

    task automatic drain(input int cycles);
        logic took;
        for (int c = 0; c < cycles; c++) begin
            tick(1'b0, 64'd0, 1'b0, 64'd0, 24'd0, 1'b0, took);
        end
    endtask

    logic [63:0] vec_a;
    logic [63:0] din_v;
    logic [63:0] exp_v;

    initial begin
        model_clear();
        vec_a = pk(8'd7, 8'd3, 8'd5, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4);

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        send(vec_a, 1'b0, pk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8), 24'd0, 1'b0);
        drain(LAT + 3);

        send(vec_a, 1'b0, pk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8), 24'd0, 1'b0);
        send(pk(8'd0, 8'd255, 8'd17, 8'd17, 8'd9, 8'd200, 8'd3, 8'd3), 1'b1,
             pk(8'd255, 8'd200, 8'd17, 8'd17, 8'd9, 8'd3, 8'd3, 8'd0), 24'd0, 1'b0);
        drain(LAT + 3);

        send({8{8'hFF}}, 1'b0, {8{8'hFF}}, 24'd0, 1'b0);
        send({8{8'h00}}, 1'b0, {8{8'h00}}, 24'd0, 1'b0);
        send(pk(8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0), 1'b0,
             pk(8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255), 24'd0, 1'b0);
        send(pk(8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0), 1'b1,
             pk(8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0), 24'd0, 1'b0);
        send(vec_a, 1'b1, pk(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1), 24'd0, 1'b0);
        drain(LAT + 3);

        // Ten permuted vectors with alternating modes under a 1,0,0,1 out_ready pattern.
        ordy_mode = 1'b1;
        nsent     = 0;
        ndeq      = 0;
        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < N; k++) begin
                din_v[k*8 +: 8] = 8'(8 * v + ((3 * k + v) % 8));
                exp_v[k*8 +: 8] = (v % 2 == 1) ? 8'(8 * v + 7 - k) : 8'(8 * v + k);
            end
            send(din_v, 1'((v % 2) == 1), exp_v, 24'd0, 1'b0);
        end
        drain(4 * (LAT + 3));
        check_eq("stream_count", 64'(ndeq), 64'd10);
        ordy_mode = 1'b0;

        // Reset with vectors in flight: nothing from before the reset may emerge.
        send(vec_a, 1'b0, pk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8), 24'd0, 1'b0);
        send(vec_a, 1'b1, pk(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1), 24'd0, 1'b0);
        send({8{8'hFF}}, 1'b0, {8{8'hFF}}, 24'd0, 1'b0);
        drain(2);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        ndeq  = 0;
        send(pk(8'd40, 8'd10, 8'd30, 8'd20, 8'd80, 8'd60, 8'd70, 8'd50), 1'b0,
             pk(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80), 24'd0, 1'b0);
        drain(LAT + 3);
        check_eq("post_rst_count", 64'(ndeq), 64'd1);

`ifdef BITONIC_TAG_EN
        send(pk(8'd5, 8'd5, 8'd1, 8'd5, 8'd1, 8'd0, 8'd9, 8'd5), 1'b0,
             pk(8'd0, 8'd1, 8'd1, 8'd5, 8'd5, 8'd5, 8'd5, 8'd9),
             pt(3'd5, 3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd7, 3'd6), 1'b1);
        drain(LAT + 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
